nes_kv260: RTL and testbench



---
 rtl/nes_kv260.sv | 132 +++++++++++++
 tb/tb_nes_kv260.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_kv260.sv
// NES-on-KV260 raster/audio shell: clk/4 dot clock, PPU scanline/cycle counters, palette test
// pattern, square-wave audio and heartbeat LED. Optional odd-frame dot skip: NES_ODD_FRAME_SKIP_EN.
module nes_kv260 #(
    parameter int unsigned H_TOTAL    = 341,
    parameter int unsigned V_TOTAL    = 262,
    parameter int unsigned TONE_HALF  = 3157,
    parameter logic [15:0] AMPLITUDE  = 16'h2000,
    parameter int unsigned LED_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    output logic        clk_ppu,
    output logic [5:0]  color,
    output logic [8:0]  scanline,
    output logic [8:0]  cycle,
    output logic [15:0] sample,
    output logic        status_led
);

    localparam int unsigned ToneW  = $clog2(TONE_HALF + 1);
    localparam int unsigned FrameW = $clog2(LED_FRAMES + 1);

    logic [1:0]        div_q, div_d;
    logic [8:0]        cycle_q, cycle_d;
    logic [8:0]        scan_q, scan_d;
    logic [5:0]        color_q, color_d;
    logic [15:0]       sample_q, sample_d;
    logic              started_q, started_d;
    logic [ToneW-1:0]  tone_q, tone_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic              parity_q, parity_d;
    logic              led_q, led_d;

    logic       dot_tick, last_line, wrap_line, wrap_frame, visible;
    logic [2:0] px_hi, py_hi;

    assign dot_tick  = (div_q == 2'd3);
    assign last_line = (scan_q == 9'(V_TOTAL - 1));

    always_comb begin
        wrap_frame = last_line && (cycle_q == 9'(H_TOTAL - 1));
`ifdef NES_ODD_FRAME_SKIP_EN
        // Odd frames drop the final dot of the last line.
        wrap_frame = wrap_frame || (last_line && parity_q && (cycle_q == 9'(H_TOTAL - 2)));
`endif
        wrap_line = (cycle_q == 9'(H_TOTAL - 1)) || wrap_frame;
    end

    always_comb begin
        div_d     = div_q + 2'd1;
        cycle_d   = cycle_q;
        scan_d    = scan_q;
        sample_d  = sample_q;
        started_d = started_q;
        tone_d    = tone_q;
        frame_d   = frame_q;
        parity_d  = parity_q;
        led_d     = led_q;

        if (dot_tick) begin
            if (wrap_line) begin
                cycle_d = 9'd0;
                scan_d  = wrap_frame ? 9'd0 : scan_q + 9'd1;
            end else begin
                cycle_d = cycle_q + 9'd1;
            end

            if (wrap_frame) begin
                parity_d = ~parity_q;
                if (frame_q == FrameW'(LED_FRAMES - 1)) begin
                    frame_d = '0;
                    led_d   = ~led_q;
                end else begin
                    frame_d = frame_q + FrameW'(1);
                end
            end

            if (!started_q) begin
                started_d = 1'b1;
                sample_d  = AMPLITUDE;
                tone_d    = '0;
            end else if (tone_q == ToneW'(TONE_HALF - 1)) begin
                tone_d   = '0;
                sample_d = 16'd0 - sample_q;
            end else begin
                tone_d = tone_q + ToneW'(1);
            end
        end
    end

    // Color is derived from the next position so it lands on the same edge as the counters.
    always_comb begin
        visible = (scan_d < 9'd240) && (cycle_d != 9'd0) && (cycle_d <= 9'd256);
        px_hi   = 3'((cycle_d - 9'd1) >> 5);
        py_hi   = 3'(scan_d >> 5);
        color_d = visible ? {py_hi, px_hi} : 6'h0F;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 2'd0;
            cycle_q   <= 9'd0;
            scan_q    <= 9'd0;
            color_q   <= 6'h0F;
            sample_q  <= 16'h0000;
            started_q <= 1'b0;
            tone_q    <= '0;
            frame_q   <= '0;
            parity_q  <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            cycle_q   <= cycle_d;
            scan_q    <= scan_d;
            color_q   <= color_d;
            sample_q  <= sample_d;
            started_q <= started_d;
            tone_q    <= tone_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            led_q     <= led_d;
        end
    end

    assign clk_ppu    = div_q[1];
    assign color      = color_q;
    assign scanline   = scan_q;
    assign cycle      = cycle_q;
    assign sample     = sample_q;
    assign status_led = led_q;

endmodule

// File: tb/tb_nes_kv260.sv
// Scoreboard bench for nes_kv260: two shrunken-raster instances checked against a dot-index model.
`timescale 1ns/1ps
module tb_nes_kv260;

    localparam int unsigned AH = 34, AV = 245, ATH = 7, ALF = 2;
    localparam int unsigned BH = 300, BV = 3, BTH = 50, BLF = 2;
    localparam logic [15:0] AMP = 16'h2000;

    typedef struct packed {
        logic [8:0]  scan;
        logic [8:0]  cyc;
        logic [5:0]  color;
        logic [15:0] sample;
        logic        led;
    } out_t;

    typedef struct {
        bit          inst_b;
        int unsigned dot;
        out_t        exp;
        string       name;
    } sb_t;

    localparam out_t RstOut = '{scan: 9'd0, cyc: 9'd0, color: 6'h0F, sample: 16'h0000, led: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        a_clk_ppu, b_clk_ppu, a_led, b_led;
    logic [5:0]  a_color, b_color;
    logic [8:0]  a_scan, b_scan, a_cyc, b_cyc;
    logic [15:0] a_sample, b_sample;

    sb_t         sb[$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned dot_now = 0;

    always #5 clk = ~clk;

    nes_kv260 #(
        .H_TOTAL(AH), .V_TOTAL(AV), .TONE_HALF(ATH), .AMPLITUDE(AMP), .LED_FRAMES(ALF)
    ) u_dut_a (
        .clk(clk), .rst(rst), .clk_ppu(a_clk_ppu), .color(a_color), .scanline(a_scan),
        .cycle(a_cyc), .sample(a_sample), .status_led(a_led)
    );

    nes_kv260 #(
        .H_TOTAL(BH), .V_TOTAL(BV), .TONE_HALF(BTH), .AMPLITUDE(AMP), .LED_FRAMES(BLF)
    ) u_dut_b (
        .clk(clk), .rst(rst), .clk_ppu(b_clk_ppu), .color(b_color), .scanline(b_scan),
        .cycle(b_cyc), .sample(b_sample), .status_led(b_led)
    );

    function automatic int unsigned frame_len(input int unsigned h, input int unsigned v,
                                              input int unsigned f);
        int unsigned l = h * v;
`ifdef NES_ODD_FRAME_SKIP_EN
        if (f % 2 == 1) l = l - 1;
`endif
        return l;
    endfunction

    function automatic int unsigned frame_start(input int unsigned h, input int unsigned v,
                                                input int unsigned f);
        int unsigned s = 0;
        for (int unsigned i = 0; i < f; i++) s += frame_len(h, v, i);
        return s;
    endfunction

    // Expected outputs after n dot ticks since reset release.
    function automatic out_t model(input int unsigned n, input int unsigned h,
                                   input int unsigned v, input int unsigned th,
                                   input int unsigned lf);
        out_t        o;
        int unsigned rem = n;
        int unsigned f = 0;
        logic [8:0]  x;
        while (rem >= frame_len(h, v, f)) begin
            rem -= frame_len(h, v, f);
            f++;
        end
        o.scan = 9'(rem / h);
        o.cyc  = 9'(rem % h);
        x      = o.cyc - 9'd1;
        if (o.scan < 9'd240 && o.cyc >= 9'd1 && o.cyc <= 9'd256) o.color = {o.scan[7:5], x[7:5]};
        else o.color = 6'h0F;
        if (n == 0) o.sample = 16'h0000;
        else if (((n - 1) / th) % 2 == 1) o.sample = 16'd0 - AMP;
        else o.sample = AMP;
        o.led = ((f / lf) % 2) == 1;
        return o;
    endfunction

    function automatic out_t obs_a();
        return {a_scan, a_cyc, a_color, a_sample, a_led};
    endfunction

    function automatic out_t obs_b();
        return {b_scan, b_cyc, b_color, b_sample, b_led};
    endfunction

    task automatic push(input bit b, input int unsigned dot, input string name);
        sb_t e;
        e.inst_b = b;
        e.dot    = dot;
        e.name   = name;
        e.exp    = b ? model(dot, BH, BV, BTH, BLF) : model(dot, AH, AV, ATH, ALF);
        sb.push_back(e);
    endtask

    task automatic advance_to(input int unsigned dot);
        if (dot > dot_now) repeat (4 * (dot - dot_now)) @(posedge clk);
        #1;
        dot_now = dot;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dot_now = 0;
    endtask

    task automatic test_reset();
        out_t got;
        repeat (3) @(negedge clk);
        got = obs_a();
        checks++;
        if (got !== RstOut || a_clk_ppu !== 1'b0)
            $display("FAIL reset_a: got %h ppu %b, required %h ppu 0", got, a_clk_ppu, RstOut);
        else passes++;
        got = obs_b();
        checks++;
        if (got !== RstOut || b_clk_ppu !== 1'b0)
            $display("FAIL reset_b: got %h ppu %b, required %h ppu 0", got, b_clk_ppu, RstOut);
        else passes++;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_clk_ppu !== ((k % 4) >= 2))
                $display("FAIL clk_ppu edge %0d: got %b, required %b", k, a_clk_ppu, (k % 4) >= 2);
            else passes++;
            if (k == 4) begin
                checks++;
                if (a_cyc !== 9'd1 || b_cyc !== 9'd1)
                    $display("FAIL first_dot: got cycle %0d/%0d, required 1", a_cyc, b_cyc);
                else passes++;
            end
        end
        dot_now = 2;
    endtask

    task automatic test_wrap_audio();
        sb_t  e;
        out_t got;
        apply_reset();
        push(1, 1, "audio_first");
        push(1, 50, "audio_hold");
        push(1, 51, "audio_neg");
        push(1, 101, "audio_pos");
        push(1, 256, "vis_x255");
        push(1, 257, "blank_x256");
        push(1, 299, "line_end");
        push(1, 300, "line_wrap");
        push(1, frame_start(BH, BV, 1) - 1, "frame0_last");
        push(1, frame_start(BH, BV, 1), "frame0_wrap");
        push(1, frame_start(BH, BV, 2) - 1, "frame1_last");
        push(1, frame_start(BH, BV, 2), "frame1_wrap");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            advance_to(e.dot);
            got = e.inst_b ? obs_b() : obs_a();
            checks++;
            if (got !== e.exp)
                $display("FAIL %s dot %0d: got (%0d,%0d) c=%h s=%h led=%b, required (%0d,%0d) c=%h s=%h led=%b",
                         e.name, e.dot, got.scan, got.cyc, got.color, got.sample, got.led,
                         e.exp.scan, e.exp.cyc, e.exp.color, e.exp.sample, e.exp.led);
            else passes++;
        end
    endtask

    task automatic test_led();
        sb_t  e;
        out_t got;
        for (int unsigned f = 3; f <= 4; f++) begin
            push(1, frame_start(BH, BV, f) - 1, "led_before");
            push(1, frame_start(BH, BV, f), "led_after");
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            advance_to(e.dot);
            got = e.inst_b ? obs_b() : obs_a();
            checks++;
            if (got !== e.exp)
                $display("FAIL %s dot %0d: got led=%b (%0d,%0d), required led=%b (%0d,%0d)",
                         e.name, e.dot, got.led, got.scan, got.cyc, e.exp.led, e.exp.scan,
                         e.exp.cyc);
            else passes++;
        end
    endtask

    task automatic test_pattern();
        sb_t  e;
        out_t got;
        apply_reset();
        push(0, 1, "pat_0_1");
        push(0, 33, "pat_0_33");
        push(0, 34, "pat_1_0");
        push(0, 10 * AH, "pat_10_0");
        push(0, 10 * AH + 33, "pat_10_33");
        push(0, 32 * AH + 33, "pat_32_33");
        push(0, 100 * AH + 20, "pat_100_20");
        push(0, 239 * AH + 1, "pat_239_1");
        push(0, 239 * AH + 33, "pat_239_33");
        push(0, 240 * AH + 5, "pat_240_5");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            advance_to(e.dot);
            got = e.inst_b ? obs_b() : obs_a();
            checks++;
            if (got !== e.exp)
                $display("FAIL %s dot %0d: got (%0d,%0d) c=%h s=%h, required (%0d,%0d) c=%h s=%h",
                         e.name, e.dot, got.scan, got.cyc, got.color, got.sample,
                         e.exp.scan, e.exp.cyc, e.exp.color, e.exp.sample);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        sb_t  e;
        out_t got;
        advance_to(dot_now + 37);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        got = obs_a();
        checks++;
        if (got !== RstOut || a_clk_ppu !== 1'b0)
            $display("FAIL mid_reset: got %h ppu %b, required %h ppu 0", got, a_clk_ppu, RstOut);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        dot_now = 0;
        push(0, 1, "restart_1");
        push(1, 2, "restart_2");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            advance_to(e.dot);
            got = e.inst_b ? obs_b() : obs_a();
            checks++;
            if (got !== e.exp)
                $display("FAIL %s dot %0d: got (%0d,%0d) s=%h, required (%0d,%0d) s=%h",
                         e.name, e.dot, got.scan, got.cyc, got.sample,
                         e.exp.scan, e.exp.cyc, e.exp.sample);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap_audio();
        test_led();
        test_pattern();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
